// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared widths, job/result field offsets and slot state encoding
// Purpose: common constants for the CSA dispatcher, collector and calc slots.
// Ports: none (package).
package csa_pkg;

  localparam int AXI_DATA_WIDTH           = 32;
  localparam int CSA_CALC_IN_WIDTH        = 48;
  localparam int CSA_CALC_OUT_WIDTH       = 2 * AXI_DATA_WIDTH;
  localparam int CSA_IN_PARAMETER_LENGTH  = AXI_DATA_WIDTH * 5;
  localparam int CSA_OUT_PARAMETER_LENGTH = AXI_DATA_WIDTH * 7;

  // Field offsets, LSB-first, shared by the job word and the echoed result word.
  localparam int BLOCK_LSB       = 0;
  localparam int IN_LSB          = 32;
  localparam int TIMES_LSB       = 96;
  localparam int TIMES_START_LSB = 128;
  localparam int OUT_LSB         = 160;

  typedef logic [1:0] csa_state_t;

  localparam csa_state_t ST_IDLE   = 2'd0;
  localparam csa_state_t ST_ISSUE  = 2'd1;
  localparam csa_state_t ST_WAIT   = 2'd2;
  localparam csa_state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/csa_calc_slot_iter.sv
// rtl/csa_calc_slot_iter.sv - iteration counter, bound compare and core_in adder
// Purpose: tracks the current iteration of a job and forms the calc input.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load_i      load load_val_i (times_start) into the counter
//   step_i      advance the counter by one
//   times_i     exclusive upper bound of the iteration range
//   in_i        job key
//   done_o      counter has reached the bound (unsigned compare)
//   core_in_o   (in + iter) mod 2^CSA_CALC_IN_WIDTH
module csa_calc_slot_iter
  import csa_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic [AXI_DATA_WIDTH-1:0]    load_val_i,
  input  logic                         step_i,
  input  logic [AXI_DATA_WIDTH-1:0]    times_i,
  input  logic [CSA_CALC_IN_WIDTH-1:0] in_i,
  output logic                         done_o,
  output logic [CSA_CALC_IN_WIDTH-1:0] core_in_o
);

  logic [AXI_DATA_WIDTH-1:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (load_i) begin
      iter_d = load_val_i;
    end else if (step_i) begin
      // Only stepped while iter < times, so this never wraps.
      iter_d = iter_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign done_o    = (iter_q >= times_i);
  // Sum is truncated to the key width; the pad bits never see a carry.
  assign core_in_o = in_i + CSA_CALC_IN_WIDTH'(iter_q);

endmodule

// File: rtl/csa_calc_slot.sv
// rtl/csa_calc_slot.sv - one calc lane: accept job, iterate external core, hold result
// Purpose: responder slot between the round-robin dispatcher and the collector.
// Build option: CSA_CALC_SLOT_OVERLAP_EN lets the next job run while a result awaits read.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   csa_in_full     slot cannot accept a job
//   csa_in_wen      job write strobe, csa_in sampled with it
//   csa_in          packed job {times_start, times, pad, in, block}
//   csa_out_ready   result held and readable
//   csa_out_ren     result read strobe
//   csa_out         packed result {out, job[159:0]}
//   core_start      one-cycle pulse starting one calc
//   core_in         calc input for the current iteration
//   core_done       calc finished, core_out valid
//   core_out        calc result
module csa_calc_slot
  import csa_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  output logic                                csa_in_full,
  input  logic                                csa_in_wen,
  input  logic [CSA_IN_PARAMETER_LENGTH-1:0]  csa_in,
  output logic                                csa_out_ready,
  input  logic                                csa_out_ren,
  output logic [CSA_OUT_PARAMETER_LENGTH-1:0] csa_out,
  output logic                                core_start,
  output logic [CSA_CALC_IN_WIDTH-1:0]        core_in,
  input  logic                                core_done,
  input  logic [CSA_CALC_OUT_WIDTH-1:0]       core_out
);

  csa_state_t                           state_q, state_d;
  logic [CSA_IN_PARAMETER_LENGTH-1:0]   job_q, job_d;
  logic                                 full_q, full_d;
  logic                                 ready_q, ready_d;
  logic                                 drain_q, drain_d;
  logic [CSA_CALC_OUT_WIDTH-1:0]        result_q, result_d;
  logic [CSA_OUT_PARAMETER_LENGTH-1:0]  out_q, out_d;
  logic                                 start_q, start_d;
  logic [CSA_CALC_IN_WIDTH-1:0]         core_in_q, core_in_d;

  logic                                 accept;
  logic                                 step;
  logic                                 iter_done;
  logic [CSA_CALC_IN_WIDTH-1:0]         iter_core_in;

  csa_calc_slot_iter u_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (csa_in[TIMES_START_LSB +: AXI_DATA_WIDTH]),
    .step_i     (step),
    .times_i    (job_q[TIMES_LSB +: AXI_DATA_WIDTH]),
    .in_i       (job_q[IN_LSB +: CSA_CALC_IN_WIDTH]),
    .done_o     (iter_done),
    .core_in_o  (iter_core_in)
  );

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    full_d    = full_q;
    ready_d   = ready_q;
    drain_d   = 1'b0;
    result_d  = result_q;
    out_d     = out_q;
    start_d   = 1'b0;
    core_in_d = core_in_q;
    accept    = 1'b0;
    step      = 1'b0;

    // drain_q blocks a load on the edge after a read so the collector,
    // which samples csa_out one cycle after ren, still sees the old value.
    if (csa_out_ren && ready_q) begin
      ready_d = 1'b0;
      drain_d = 1'b1;
`ifndef CSA_CALC_SLOT_OVERLAP_EN
      full_d  = 1'b0;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (csa_in_wen && !full_q) begin
          accept   = 1'b1;
          job_d    = csa_in;
          full_d   = 1'b1;
          result_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (iter_done) begin
          state_d = ST_FINISH;
        end else begin
          start_d   = 1'b1;
          core_in_d = iter_core_in;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          result_d = core_out;
          step     = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        if (!ready_q && !drain_q) begin
          out_d   = {result_q, job_q};
          ready_d = 1'b1;
`ifdef CSA_CALC_SLOT_OVERLAP_EN
          full_d  = 1'b0;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      job_q     <= '0;
      full_q    <= 1'b0;
      ready_q   <= 1'b0;
      drain_q   <= 1'b0;
      result_q  <= '0;
      out_q     <= '0;
      start_q   <= 1'b0;
      core_in_q <= '0;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
      drain_q   <= drain_d;
      result_q  <= result_d;
      out_q     <= out_d;
      start_q   <= start_d;
      core_in_q <= core_in_d;
    end
  end

  assign csa_in_full   = full_q;
  assign csa_out_ready = ready_q;
  assign csa_out       = out_q;
  assign core_start    = start_q;
  assign core_in       = core_in_q;

endmodule

// File: tb/tb_csa_calc_slot.sv
// tb/tb_csa_calc_slot.sv - directed self-checking bench for csa_calc_slot
module tb_csa_calc_slot;

  logic         clk;
  logic         rst;
  logic         csa_in_full;
  logic         csa_in_wen;
  logic [159:0] csa_in;
  logic         csa_out_ready;
  logic         csa_out_ren;
  logic [223:0] csa_out;
  logic         core_start;
  logic [47:0]  core_in;
  logic         core_done;
  logic [63:0]  core_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] starts[$];
  int          pend;

  csa_calc_slot dut (
    .clk           (clk),
    .rst           (rst),
    .csa_in_full   (csa_in_full),
    .csa_in_wen    (csa_in_wen),
    .csa_in        (csa_in),
    .csa_out_ready (csa_out_ready),
    .csa_out_ren   (csa_out_ren),
    .csa_out       (csa_out),
    .core_start    (core_start),
    .core_in       (core_in),
    .core_done     (core_done),
    .core_out      (core_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: result = in + 0xA5, core_done three edges after core_start is seen.
  initial begin
    logic [47:0] cap;
    core_done = 1'b0;
    core_out  = '0;
    pend      = 0;
    cap       = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (core_start) begin
        starts.push_back(core_in);
        cap  = core_in;
        pend = 2;
      end else if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          core_done = 1'b1;
          core_out  = {16'h0, cap} + 64'hA5;
        end
      end
    end
  end

  function automatic logic [159:0] mk_job(input logic [31:0] ts, input logic [31:0] tm,
                                          input logic [15:0] pad, input logic [47:0] in48,
                                          input logic [31:0] blk);
    return {ts, tm, pad, in48, blk};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_job(input logic [159:0] job);
    csa_in     = job;
    csa_in_wen = 1'b1;
    tick();
    csa_in_wen = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!csa_out_ready && cyc < 500) begin
      tick();
      cyc++;
    end
    if (!csa_out_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: ready timeout, got ready=%0b want 1", name, csa_out_ready);
    end
  endtask

  task automatic do_read();
    csa_out_ren = 1'b1;
    tick();
    csa_out_ren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (csa_in_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %0b want 0", csa_in_full); end
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", csa_out_ready); end
    n_cmp++; if (csa_out !== 224'h0) begin n_bad++; $display("FAIL rst_out: got %h want 0", csa_out); end
    n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %0b want 0", core_start); end
    n_cmp++; if (core_in !== 48'h0) begin n_bad++; $display("FAIL rst_core_in: got %h want 0", core_in); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_iterations();
    logic [159:0] job;
    logic [223:0] held;
    bit           seq_ok;
    starts.delete();
    job = mk_job(32'd0, 32'd10, 16'h0, 48'd1, 32'd1);
    send_job(job);
    n_cmp++; if (csa_in_full !== 1'b1) begin n_bad++; $display("FAIL iter_full_rise: got %0b want 1", csa_in_full); end
    wait_ready("iter");
    n_cmp++; if (starts.size() !== 10) begin n_bad++; $display("FAIL iter_starts: got %0d want 10", starts.size()); end
    seq_ok = 1'b1;
    for (int i = 0; i < starts.size() && i < 10; i++)
      if (starts[i] !== 48'(i + 1)) seq_ok = 1'b0;
    n_cmp++; if (!seq_ok) begin n_bad++; $display("FAIL iter_core_in_seq: got first=%h want 1..10", starts.size() > 0 ? starts[0] : 48'h0); end
    n_cmp++; if (csa_out[223:160] !== 64'hAF) begin n_bad++; $display("FAIL iter_out: got %h want af", csa_out[223:160]); end
    n_cmp++; if (csa_out[159:0] !== job) begin n_bad++; $display("FAIL iter_echo: got %h want %h", csa_out[159:0], job); end
    n_cmp++; if (csa_out[127:96] !== 32'd10) begin n_bad++; $display("FAIL iter_times: got %0d want 10", csa_out[127:96]); end
    n_cmp++; if (csa_in_full !== 1'b1) begin n_bad++; $display("FAIL iter_full_hold: got %0b want 1", csa_in_full); end
    held = csa_out;
    do_read();
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL iter_ren_ready: got %0b want 0", csa_out_ready); end
`ifndef CSA_CALC_SLOT_OVERLAP_EN
    n_cmp++; if (csa_in_full !== 1'b0) begin n_bad++; $display("FAIL iter_ren_full: got %0b want 0", csa_in_full); end
`endif
    n_cmp++; if (csa_out !== held) begin n_bad++; $display("FAIL iter_hold_ren: got %h want %h", csa_out, held); end
    tick();
    n_cmp++; if (csa_out !== held) begin n_bad++; $display("FAIL iter_hold_next: got %h want %h", csa_out, held); end
  endtask

  task automatic test_zero_iter();
    starts.delete();
    send_job(mk_job(32'd5, 32'd5, 16'h0, 48'h77, 32'd3));
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready_e0: got %0b want 0", csa_out_ready); end
    tick();
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready_e1: got %0b want 0", csa_out_ready); end
    tick();
    n_cmp++; if (csa_out_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready_e2: got %0b want 1", csa_out_ready); end
    n_cmp++; if (starts.size() !== 0) begin n_bad++; $display("FAIL zero_starts: got %0d want 0", starts.size()); end
    n_cmp++; if (csa_out[223:160] !== 64'h0) begin n_bad++; $display("FAIL zero_out: got %h want 0", csa_out[223:160]); end
    n_cmp++; if (csa_out[31:0] !== 32'd3) begin n_bad++; $display("FAIL zero_block: got %0d want 3", csa_out[31:0]); end
    do_read();
    tick();
  endtask

  task automatic test_carry();
    starts.delete();
    send_job(mk_job(32'd0, 32'd2, 16'h1234, 48'hFFFF_FFFF_FFFF, 32'd4));
    wait_ready("carry");
    n_cmp++; if (starts.size() !== 2) begin n_bad++; $display("FAIL carry_starts: got %0d want 2", starts.size()); end
    if (starts.size() == 2) begin
      n_cmp++; if (starts[0] !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL carry_in0: got %h want ffffffffffff", starts[0]); end
      n_cmp++; if (starts[1] !== 48'h0) begin n_bad++; $display("FAIL carry_in1: got %h want 0", starts[1]); end
    end
    n_cmp++; if (csa_out[95:80] !== 16'h1234) begin n_bad++; $display("FAIL carry_pad: got %h want 1234", csa_out[95:80]); end
    n_cmp++; if (csa_out[223:160] !== 64'hA5) begin n_bad++; $display("FAIL carry_out: got %h want a5", csa_out[223:160]); end
    do_read();
    tick();
  endtask

  task automatic test_wen_while_full();
    starts.delete();
    send_job(mk_job(32'd0, 32'd1, 16'h0, 48'd3, 32'd7));
    csa_in     = mk_job(32'd0, 32'd1, 16'h0, 48'd9, 32'd9);
    csa_in_wen = 1'b1;
    wait_ready("wen_full");
    csa_in_wen = 1'b0;
    n_cmp++; if (csa_out[31:0] !== 32'd7) begin n_bad++; $display("FAIL wenfull_block: got %0d want 7", csa_out[31:0]); end
    n_cmp++; if (csa_out[223:160] !== 64'hA8) begin n_bad++; $display("FAIL wenfull_out: got %h want a8", csa_out[223:160]); end
    do_read();
    repeat (20) tick();
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL wenfull_extra: got ready=%0b want 0", csa_out_ready); end
    n_cmp++; if (starts.size() !== 1) begin n_bad++; $display("FAIL wenfull_starts: got %0d want 1", starts.size()); end
  endtask

  task automatic test_rst_mid_job();
    int cyc = 0;
    starts.delete();
    send_job(mk_job(32'd0, 32'd10, 16'h0, 48'd1, 32'd1));
    while (starts.size() == 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    n_cmp++; if (starts.size() !== 1) begin n_bad++; $display("FAIL rstmid_started: got %0d want 1", starts.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (csa_in_full !== 1'b0) begin n_bad++; $display("FAIL rstmid_full: got %0b want 0", csa_in_full); end
    n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_start: got %0b want 0", core_start); end
    n_cmp++; if (core_in !== 48'h0) begin n_bad++; $display("FAIL rstmid_core_in: got %h want 0", core_in); end
    n_cmp++; if (csa_out !== 224'h0) begin n_bad++; $display("FAIL rstmid_out: got %h want 0", csa_out); end
    repeat (6) tick();
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_ready: got %0b want 0", csa_out_ready); end
    n_cmp++; if (csa_in_full !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_full: got %0b want 0", csa_in_full); end
    n_cmp++; if (starts.size() !== 1) begin n_bad++; $display("FAIL rstmid_late_starts: got %0d want 1", starts.size()); end
    send_job(mk_job(32'd0, 32'd1, 16'h0, 48'h10, 32'd2));
    wait_ready("rst_fresh");
    n_cmp++; if (csa_out[223:160] !== 64'hB5) begin n_bad++; $display("FAIL rstmid_fresh_out: got %h want b5", csa_out[223:160]); end
    n_cmp++; if (csa_out[31:0] !== 32'd2) begin n_bad++; $display("FAIL rstmid_fresh_block: got %0d want 2", csa_out[31:0]); end
    do_read();
    tick();
  endtask

`ifdef CSA_CALC_SLOT_OVERLAP_EN
  task automatic test_back_to_back();
    send_job(mk_job(32'd0, 32'd0, 16'h0, 48'd5, 32'd1));
    wait_ready("ovl_job1");
    n_cmp++; if (csa_in_full !== 1'b0) begin n_bad++; $display("FAIL ovl_full_free: got %0b want 0", csa_in_full); end
    send_job(mk_job(32'd0, 32'd1, 16'h0, 48'd5, 32'd2));
    repeat (20) tick();
    n_cmp++; if (csa_in_full !== 1'b1) begin n_bad++; $display("FAIL ovl_stall_full: got %0b want 1", csa_in_full); end
    n_cmp++; if (csa_out[31:0] !== 32'd1) begin n_bad++; $display("FAIL ovl_stall_block: got %0d want 1", csa_out[31:0]); end
    do_read();
    n_cmp++; if (csa_out[31:0] !== 32'd1) begin n_bad++; $display("FAIL ovl_ren_edge: got %0d want 1", csa_out[31:0]); end
    tick();
    n_cmp++; if (csa_out[31:0] !== 32'd1) begin n_bad++; $display("FAIL ovl_drain_edge: got %0d want 1", csa_out[31:0]); end
    n_cmp++; if (csa_out_ready !== 1'b0) begin n_bad++; $display("FAIL ovl_drain_ready: got %0b want 0", csa_out_ready); end
    tick();
    n_cmp++; if (csa_out[31:0] !== 32'd2) begin n_bad++; $display("FAIL ovl_load2: got %0d want 2", csa_out[31:0]); end
    n_cmp++; if (csa_out[223:160] !== 64'hAA) begin n_bad++; $display("FAIL ovl_out2: got %h want aa", csa_out[223:160]); end
    n_cmp++; if (csa_out_ready !== 1'b1) begin n_bad++; $display("FAIL ovl_ready2: got %0b want 1", csa_out_ready); end
    do_read();
    tick();
  endtask
`endif

  initial begin
    rst         = 1'b1;
    csa_in_wen  = 1'b0;
    csa_in      = '0;
    csa_out_ren = 1'b0;
    test_reset();
    test_iterations();
    test_zero_iter();
    test_carry();
    test_wen_while_full();
    test_rst_mid_job();
`ifdef CSA_CALC_SLOT_OVERLAP_EN
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
